misao_mem_responder: RTL

- Bus-slave end of the misao core memory interface: services core fetch/load reads and store writes to a byte-wide on-chip RAM.
- Adds a small memory-mapped I/O window: a status/control register and a transmit FIFO drained by a valid/ready sink.
- Sits between the misao core and the SoC top; replaces the behavioural memory model used in core-level benches.

---
 rtl/misao_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/misao_mem_responder.sv
// misao_mem_responder
//
// Bus-slave end of the misao core memory interface. It serves core fetch/load
// reads and store writes to a byte-wide on-chip RAM. It also provides a
// two-byte memory-mapped I/O window: a status/control register, and a
// transmit FIFO that a valid/ready sink drains.
//
// Address map:
//   0 .. RAM_DEPTH-1 : RAM (reads are combinational, writes commit on clk)
//   IO_BASE+0        : status {overflow, bus_error, full, empty, 0, count[2:0]}
//                      write-1-to-clear: bit7 = overflow, bit6 = bus_error
//   IO_BASE+1        : read = last byte pushed, write = push into TX FIFO
//   anything else    : reads 8'h00, sets bus_error
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   mem_enable_read/_write         core strobes
//   mem_addr, mem_rw               core byte address, direction (1 = write)
//   mem_data_out                   write data from the core
//   mem_data_in                    read data back to the core (same cycle)
//   load_en/load_addr/load_data    RAM preload port (works during reset)
//   tx_valid/tx_data/tx_ready      first-word-fall-through FIFO head to sink
//   bus_error                      sticky protocol/decode error flag
module misao_mem_responder #(
  parameter int                ADDR_W     = 15,
  parameter int                RAM_DEPTH  = 256,
  parameter logic [ADDR_W-1:0] IO_BASE    = 15'h7F00,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable_read,
  input  logic              mem_enable_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rw,
  input  logic [7:0]        mem_data_out,
  output logic [7:0]        mem_data_in,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              bus_error
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] IO_DATA   = IO_BASE + ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [7:0]       ram      [RAM_DEPTH];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       last_push;
  logic             overflow;

  logic       hit_ram;
  logic       hit_stat;
  logic       hit_data;
  logic       mapped;
  logic       fifo_empty;
  logic       fifo_full;
  logic [3:0] count_ext;
  logic [7:0] status;

  assign hit_ram    = mem_addr < RAM_LIMIT;
  assign hit_stat   = mem_addr == IO_BASE;
  assign hit_data   = mem_addr == IO_DATA;
  assign mapped     = hit_ram | hit_stat | hit_data;
  assign fifo_empty = count == '0;
  assign fifo_full  = count == CNT_FULL;
  assign count_ext  = 4'(count);
  assign status     = {overflow, bus_error, fifo_full, fifo_empty, 1'b0, count_ext[2:0]};

  // The core has no ready input, so read data must be valid in the same
  // cycle as the strobe. The RAM is therefore read asynchronously.
  always_comb begin
    mem_data_in = 8'h00;
    if (mem_enable_read) begin
      if (hit_ram)       mem_data_in = ram[mem_addr[RAM_AW-1:0]];
      else if (hit_stat) mem_data_in = status;
      else if (hit_data) mem_data_in = last_push;
    end
  end

  logic core_ram_wr;
  logic load_hit;
  logic load_conflict;

  assign core_ram_wr   = mem_enable_write & hit_ram;
  assign load_hit      = load_en & (load_addr < RAM_LIMIT);
  // Any preload cycle blocks the core's RAM write, and the collision is flagged.
  assign load_conflict = load_en & core_ram_wr;

  // The RAM has no reset, so the boot loader can fill it while rst is held.
  always_ff @(posedge clk) begin
    if (load_hit)
      ram[load_addr[RAM_AW-1:0]] <= load_data;
    else if (core_ram_wr && !load_en)
      ram[mem_addr[RAM_AW-1:0]] <= mem_data_out;
  end

  logic push;
  logic pop;
  logic push_ok;
  logic err_set;
  logic clr_ovf;
  logic clr_err;

  assign push    = mem_enable_write & hit_data;
  assign pop     = tx_valid & tx_ready;
  // When the FIFO is full, a push is accepted only if the head leaves in the same cycle.
  assign push_ok = push & (~fifo_full | pop);
  assign err_set = (mem_enable_read & mem_enable_write)
                 | (mem_enable_write & ~mem_rw)
                 | (mem_enable_read & mem_rw)
                 | (mem_enable_read & ~mapped)
                 | (mem_enable_write & ~mapped)
                 | load_conflict;
  assign clr_ovf = mem_enable_write & hit_stat & mem_data_out[7];
  assign clr_err = mem_enable_write & hit_stat & mem_data_out[6];

  // FIFO state and sticky flags. A set event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_push <= 8'h00;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= mem_data_out;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push) last_push <= mem_data_out;
      overflow  <= (overflow & ~clr_ovf) | (push & ~push_ok);
      bus_error <= (bus_error & ~clr_err) | err_set;
    end
  end

  // tx_valid is taken from the count, which is reset asynchronously.
  // So the handshake drops as soon as rst rises.
  assign tx_valid = ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

endmodule
